// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Optional build macro: ICACHE_STATS_EN (adds hit/miss counters on the top).
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        REFILL_REQ  = 2'd1,
        REFILL_WAIT = 2'd2,
        RESPOND     = 2'd3
    } state_t;

    // Widths for the default geometry (32-bit addresses, 64 lines, 4 words/line).
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_NUM_LINES  = 64;
    localparam int DEF_WPL        = 4;
    localparam int OFFSET_W       = $clog2(DEF_WPL);
    localparam int INDEX_W        = $clog2(DEF_NUM_LINES);
    localparam int TAG_W          = DEF_ADDR_WIDTH - INDEX_W - OFFSET_W - 2;

    // RV32I canonical NOP (addi x0, x0, 0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Saturating 32-bit increment for event counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and backing-memory-side signal bundle of the instruction cache.
// slave = cache side, master = fetch unit / memory side (testbench).
interface icache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  fetch_req_valid;
    logic                  fetch_req_ready;
    logic [ADDR_WIDTH-1:0] fetch_req_addr;
    logic                  fetch_rsp_valid;
    logic [DATA_WIDTH-1:0] fetch_rsp_instr;
    logic                  flush;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;

    modport slave (
        input  fetch_req_valid, fetch_req_addr, flush,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output fetch_req_ready, fetch_rsp_valid, fetch_rsp_instr,
               mem_req_valid, mem_req_addr
    );

    modport master (
        output fetch_req_valid, fetch_req_addr, flush,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_instr,
               mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/icache_line_store.sv
// Data, tag and valid storage for the direct-mapped cache.
// One combinational read port, one beat write port, tag write and flush-all.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = INDEX_W,
    parameter int OFF_W      = OFFSET_W,
    parameter int TG_W       = TAG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      i_rd_idx,
    input  logic [OFF_W-1:0]      i_rd_off,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic [TG_W-1:0]       o_rd_tag,
    output logic                  o_rd_valid,
    input  logic                  i_wr_en,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [OFF_W-1:0]      i_wr_off,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_tag_we,
    input  logic [TG_W-1:0]       i_wr_tag,
    input  logic                  i_set_valid,
    input  logic                  i_flush
);
    localparam int NUM_LINES = 1 << IDX_W;
    localparam int NUM_WORDS = 1 << (IDX_W + OFF_W);

    logic [DATA_WIDTH-1:0] r_data [NUM_WORDS];
    logic [TG_W-1:0]       r_tag  [NUM_LINES];
    logic [NUM_LINES-1:0]  r_valid;

    assign o_rd_data  = r_data[{i_rd_idx, i_rd_off}];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_valid = r_valid[i_rd_idx];

    // Refill beats and tags land in storage; these arrays are never reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[{i_wr_idx, i_wr_off}] <= i_wr_data;
        end
        if (i_tag_we) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
    end

    // Valid bits: flush wins over a concurrent line install.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_valid <= '0;
        end else if (i_tag_we) begin
            r_valid[i_wr_idx] <= i_set_valid;
        end
    end

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped L1 instruction cache with a line-refill FSM.
// Optional build macro: ICACHE_STATS_EN adds stat_hits / stat_misses outputs.
module icache_direct_mapped
    import icache_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          NUM_LINES      = 64,
    parameter int          WORDS_PER_LINE = 4,
    parameter logic [31:0] RESET_INSTR    = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    icache_if.slave     bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TG_W  = ADDR_WIDTH - IDX_W - OFF_W - 2;

    state_t                r_state;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_instr;
    logic                  r_mem_req_valid;
    logic [ADDR_WIDTH-1:0] r_mem_req_addr;
    logic [OFF_W-1:0]      r_beat;
    logic                  r_flushed;
    logic [TG_W-1:0]       r_tag;
    logic [IDX_W-1:0]      r_idx;
    logic [OFF_W-1:0]      r_off;

    logic [TG_W-1:0]       w_req_tag;
    logic [IDX_W-1:0]      w_req_idx;
    logic [OFF_W-1:0]      w_req_off;
    logic [1:0]            w_unused_lsb;
    logic                  w_accept;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [OFF_W-1:0]      w_rd_off;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [TG_W-1:0]       w_rd_tag;
    logic                  w_rd_valid;
    logic                  w_wr_en;
    logic                  w_last_beat;
    logic [DATA_WIDTH-1:0] w_last_word;

    assign w_req_tag    = bus.fetch_req_addr[ADDR_WIDTH-1 -: TG_W];
    assign w_req_idx    = bus.fetch_req_addr[OFF_W+2 +: IDX_W];
    assign w_req_off    = bus.fetch_req_addr[2 +: OFF_W];
    assign w_unused_lsb = bus.fetch_req_addr[1:0];

    assign w_accept = bus.fetch_req_valid && (r_state == IDLE);
    // Lookup uses the incoming address in IDLE, the latched one during refill.
    assign w_rd_idx = (r_state == IDLE) ? w_req_idx : r_idx;
    assign w_rd_off = (r_state == IDLE) ? w_req_off : r_off;
    assign w_hit    = w_rd_valid && (w_rd_tag == w_req_tag);

    assign w_wr_en     = (r_state == REFILL_WAIT) && bus.mem_rsp_valid;
    assign w_last_beat = w_wr_en && (r_beat == OFF_W'(WORDS_PER_LINE - 1));
    // The final beat is not in the array yet, so bypass it if it is the requested word.
    assign w_last_word = (r_off == r_beat) ? bus.mem_rsp_data : w_rd_data;

    assign bus.fetch_req_ready = (r_state == IDLE);
    assign bus.fetch_rsp_valid = r_rsp_valid;
    assign bus.fetch_rsp_instr = r_rsp_instr;
    assign bus.mem_req_valid   = r_mem_req_valid;
    assign bus.mem_req_addr    = r_mem_req_addr;

    icache_line_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W),
        .OFF_W      (OFF_W),
        .TG_W       (TG_W)
    ) u_store (
        .clk         (clk),
        .rst         (rst),
        .i_rd_idx    (w_rd_idx),
        .i_rd_off    (w_rd_off),
        .o_rd_data   (w_rd_data),
        .o_rd_tag    (w_rd_tag),
        .o_rd_valid  (w_rd_valid),
        .i_wr_en     (w_wr_en),
        .i_wr_idx    (r_idx),
        .i_wr_off    (r_beat),
        .i_wr_data   (bus.mem_rsp_data),
        .i_tag_we    (w_last_beat),
        .i_wr_tag    (r_tag),
        .i_set_valid (!(r_flushed || bus.flush)),
        .i_flush     (bus.flush)
    );

    // Latch the split address of every accepted request (datapath, no reset).
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag <= w_req_tag;
            r_idx <= w_req_idx;
            r_off <= w_req_off;
        end
    end

    // Lookup / refill FSM with registered response and memory-request outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_rsp_valid     <= 1'b0;
            r_rsp_instr     <= RESET_INSTR[DATA_WIDTH-1:0];
            r_mem_req_valid <= 1'b0;
            r_mem_req_addr  <= '0;
            r_beat          <= '0;
            r_flushed       <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_flushed <= 1'b0;
                        if (w_hit && !bus.flush) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_instr <= w_rd_data;
                        end else begin
                            r_state         <= REFILL_REQ;
                            r_mem_req_valid <= 1'b1;
                            r_mem_req_addr  <= {w_req_tag, w_req_idx, {(OFF_W+2){1'b0}}};
                        end
                    end
                end
                REFILL_REQ: begin
                    if (bus.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_beat          <= '0;
                        r_state         <= REFILL_WAIT;
                    end
                end
                REFILL_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        r_beat <= r_beat + OFF_W'(1);
                        if (w_last_beat) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_instr <= w_last_word;
                            r_state     <= RESPOND;
                        end
                    end
                end
                RESPOND: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            // A flush seen at any point of a refill keeps that line from being installed.
            if (bus.flush && (r_state != IDLE)) begin
                r_flushed <= 1'b1;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    // Saturating hit/miss counters over accepted requests; flush does not touch them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (w_accept) begin
            if (w_hit && !bus.flush) begin
                stat_hits <= sat_inc(stat_hits);
            end else begin
                stat_misses <= sat_inc(stat_misses);
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed testbench for icache_direct_mapped (default geometry).
// Optional build macro: ICACHE_STATS_EN enables the counter checks.
module tb_icache_direct_mapped;

    logic clk;
    logic rst;

    icache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    icache_direct_mapped #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .NUM_LINES      (64),
        .WORDS_PER_LINE (4),
        .RESET_INSTR    (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;
    logic [31:0] beats [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_line0();
        beats[0] = 32'h0050_0093;
        beats[1] = 32'h0030_0113;
        beats[2] = 32'h0020_81b3;
        beats[3] = 32'h4020_8233;
    endtask

    task automatic set_beats(input logic [31:0] base);
        for (int i = 0; i < 4; i++) beats[i] = base + 32'(i);
    endtask

    // Miss path: accept, request (optionally stalled), 4 beats, one response pulse.
    task automatic refill(input string tag, input logic [31:0] addr, input int stall,
                          input int flush_at, input logic [31:0] exp_word);
        bus.fetch_req_valid = 1'b1;
        bus.fetch_req_addr  = addr;
        step();
        bus.fetch_req_valid = 1'b0;
        chk($sformatf("%s_mreq_valid", tag), {31'd0, bus.mem_req_valid}, 32'd1);
        chk($sformatf("%s_mreq_addr", tag), bus.mem_req_addr, addr & 32'hFFFF_FFF0);
        chk($sformatf("%s_ready_low", tag), {31'd0, bus.fetch_req_ready}, 32'd0);
        for (int s = 0; s < stall; s++) begin
            step();
            chk($sformatf("%s_stall%0d_valid", tag, s), {31'd0, bus.mem_req_valid}, 32'd1);
            chk($sformatf("%s_stall%0d_addr", tag, s), bus.mem_req_addr, addr & 32'hFFFF_FFF0);
            chk($sformatf("%s_stall%0d_ready", tag, s), {31'd0, bus.fetch_req_ready}, 32'd0);
        end
        // A beat coinciding with the request handshake must be ignored.
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hDEAD_BEEF;
        step();
        bus.mem_req_ready = 1'b0;
        chk($sformatf("%s_mreq_dropped", tag), {31'd0, bus.mem_req_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = beats[i];
            bus.flush         = (i == flush_at);
            step();
            if (i < 3) chk($sformatf("%s_beat%0d_no_rsp", tag, i), {31'd0, bus.fetch_rsp_valid}, 32'd0);
        end
        bus.mem_rsp_valid = 1'b0;
        bus.flush         = 1'b0;
        chk($sformatf("%s_rsp_valid", tag), {31'd0, bus.fetch_rsp_valid}, 32'd1);
        chk($sformatf("%s_rsp_instr", tag), bus.fetch_rsp_instr, exp_word);
        step();
        chk($sformatf("%s_rsp_pulse_end", tag), {31'd0, bus.fetch_rsp_valid}, 32'd0);
        chk($sformatf("%s_ready_back", tag), {31'd0, bus.fetch_req_ready}, 32'd1);
    endtask

    task automatic hit(input string tag, input logic [31:0] addr, input logic [31:0] exp_word);
        bus.fetch_req_valid = 1'b1;
        bus.fetch_req_addr  = addr;
        step();
        bus.fetch_req_valid = 1'b0;
        chk($sformatf("%s_rsp_valid", tag), {31'd0, bus.fetch_rsp_valid}, 32'd1);
        chk($sformatf("%s_rsp_instr", tag), bus.fetch_rsp_instr, exp_word);
        chk($sformatf("%s_no_mreq", tag), {31'd0, bus.mem_req_valid}, 32'd0);
    endtask

    initial begin
        rst                 = 1'b1;
        bus.fetch_req_valid = 1'b0;
        bus.fetch_req_addr  = '0;
        bus.flush           = 1'b0;
        bus.mem_req_ready   = 1'b0;
        bus.mem_rsp_valid   = 1'b0;
        bus.mem_rsp_data    = '0;
        step();
        step();
        rst = 1'b0;

        // Reset values
        chk("rst_ready", {31'd0, bus.fetch_req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.fetch_rsp_valid}, 32'd0);
        chk("rst_instr", bus.fetch_rsp_instr, 32'h0000_0013);
        chk("rst_mreq_valid", {31'd0, bus.mem_req_valid}, 32'd0);
        chk("rst_mreq_addr", bus.mem_req_addr, 32'h0);

        // Cold miss on 0x0, then hits in the same line
        set_line0();
        refill("miss0", 32'h0, 0, -1, 32'h0050_0093);
        hit("hit8", 32'h8, 32'h0020_81b3);
        step();
        chk("idle_rsp_low", {31'd0, bus.fetch_rsp_valid}, 32'd0);

        // Back-to-back hits, one per cycle
        bus.fetch_req_valid = 1'b1;
        bus.fetch_req_addr  = 32'h4;
        step();
        chk("b2b_first", bus.fetch_rsp_instr, 32'h0030_0113);
        chk("b2b_first_v", {31'd0, bus.fetch_rsp_valid}, 32'd1);
        bus.fetch_req_addr  = 32'hC;
        step();
        bus.fetch_req_valid = 1'b0;
        chk("b2b_second", bus.fetch_rsp_instr, 32'h4020_8233);
        chk("b2b_second_v", {31'd0, bus.fetch_rsp_valid}, 32'd1);
        step();
        chk("hold_instr", bus.fetch_rsp_instr, 32'h4020_8233);

        // Conflict miss on index 0, then refetch 0x0 with a 5-cycle request stall
        set_beats(32'h1111_0000);
        refill("conf400", 32'h400, 0, -1, 32'h1111_0000);
        set_line0();
        refill("refetch0", 32'h0, 5, -1, 32'h0050_0093);

        // Flush during refill: word still returned, line left invalid
        set_beats(32'h2000_0000);
        refill("flush_rf", 32'h2C, 0, 1, 32'h2000_0003);
        refill("after_flush", 32'h2C, 0, -1, 32'h2000_0003);
        hit("hit28", 32'h28, 32'h2000_0002);

        // Flush while idle invalidates everything
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        refill("idle_flush", 32'h28, 0, -1, 32'h2000_0002);

        // Request accepted together with flush is a miss
        bus.fetch_req_valid = 1'b1;
        bus.fetch_req_addr  = 32'h24;
        bus.flush           = 1'b1;
        step();
        bus.fetch_req_valid = 1'b0;
        bus.flush           = 1'b0;
        chk("flush_accept_miss", {31'd0, bus.mem_req_valid}, 32'd1);
        chk("flush_accept_norsp", {31'd0, bus.fetch_rsp_valid}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Reset in the middle of a refill
        set_line0();
        bus.fetch_req_valid = 1'b1;
        bus.fetch_req_addr  = 32'h0;
        step();
        bus.fetch_req_valid = 1'b0;
        bus.mem_req_ready   = 1'b1;
        step();
        bus.mem_req_ready   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = beats[i];
            step();
        end
        rst              = 1'b1;
        bus.mem_rsp_data = beats[2];
        step();
        rst = 1'b0;
        chk("midrst_rsp_valid", {31'd0, bus.fetch_rsp_valid}, 32'd0);
        chk("midrst_mreq_valid", {31'd0, bus.mem_req_valid}, 32'd0);
        chk("midrst_ready", {31'd0, bus.fetch_req_ready}, 32'd1);
        chk("midrst_instr", bus.fetch_rsp_instr, 32'h0000_0013);
        bus.mem_rsp_data = beats[3];
        step();
        bus.mem_rsp_valid = 1'b0;
        chk("late_beat_rsp", {31'd0, bus.fetch_rsp_valid}, 32'd0);
        chk("late_beat_mreq", {31'd0, bus.mem_req_valid}, 32'd0);
        refill("post_rst", 32'h0, 0, -1, 32'h0050_0093);

`ifdef ICACHE_STATS_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("stat_rst_hits", stat_hits, 32'd0);
        chk("stat_rst_misses", stat_misses, 32'd0);
        set_line0();
        refill("st0", 32'h0, 0, -1, 32'h0050_0093);
        hit("st4", 32'h4, 32'h0030_0113);
        hit("st8", 32'h8, 32'h0020_81b3);
        set_beats(32'h1111_0000);
        refill("st400", 32'h400, 0, -1, 32'h1111_0000);
        set_line0();
        refill("st0b", 32'h0, 0, -1, 32'h0050_0093);
        chk("stat_hits", stat_hits, 32'd2);
        chk("stat_misses", stat_misses, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
Parametrised direct-mapped L1 instruction cache for the IF stage. It replaces the combinational instruction ROM with tag/valid-checked line storage and a refill FSM that fetches whole lines from a backing memory over a valid/ready request and a beat-wise response. Requests on the fetch side use a valid/ready handshake; responses are single-cycle pulses.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, instruction/beat width
NUM_LINES, 64, cache lines; power of 2
WORDS_PER_LINE, 4, words per line; power of 2, >=2
RESET_INSTR, 32'h0000_0013, value driven on fetch_rsp_instr at reset (NOP)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
fetch_req_valid  in  1  fetch request
fetch_req_ready  out  1  cache can accept a request
fetch_req_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
fetch_rsp_valid  out  1  one-cycle pulse; instruction valid
fetch_rsp_instr  out  DATA_WIDTH  fetched instruction
flush  in  1  invalidate all lines
mem_req_valid  out  1  line refill request
mem_req_ready  in  1  backing memory accepts request
mem_req_addr  out  ADDR_WIDTH  line-aligned byte address
mem_rsp_valid  in  1  refill beat valid
mem_rsp_data  in  DATA_WIDTH  refill beat, ascending word order

Behaviour:
- Address split: offset = addr[log2(WPL)+1:2], index = next log2(NUM_LINES) bits, tag = remaining upper bits.
- Reset: state IDLE, all valid bits 0, fetch_req_ready 1, fetch_rsp_valid 0, fetch_rsp_instr RESET_INSTR, mem_req_valid 0, mem_req_addr 0. Data and tag arrays are not reset.
- FSM states: IDLE, REFILL_REQ, REFILL_WAIT, RESPOND.
- IDLE: fetch_req_ready=1. On accept (valid&&ready), latch the address. On a hit (valid[index] && tag match), fetch_rsp_valid=1 with the word in the next cycle and state stays IDLE. Back-to-back hits run at one per cycle. On a miss, go to REFILL_REQ.
- REFILL_REQ: fetch_req_ready=0. mem_req_valid=1 with mem_req_addr = {tag,index,0...}, held stable until mem_req_ready. On handshake, go to REFILL_WAIT with beat counter = 0.
- REFILL_WAIT: each mem_rsp_valid writes the beat at the counter position and increments the counter. A beat arriving in the same cycle as the request handshake is ignored. On the last beat (counter = WPL-1), write the tag, set valid unless a flush occurred during this refill, and go to RESPOND.
- RESPOND: fetch_rsp_valid=1 with the requested word, then return to IDLE. Miss latency = handshake + WPL beats + 1 cycle.
- flush: clears all valid bits in the next cycle. In IDLE, flush takes priority over lookup. A request accepted in the same cycle as flush is treated as a miss. During a refill, the refill completes, the instruction is returned, and the line is left invalid.
- mem_rsp_valid outside REFILL_WAIT is ignored.
- rst mid-refill: back to IDLE in the next cycle, all outputs at reset values, and the pending request is dropped with no response.
- fetch_rsp_instr holds its last value when fetch_rsp_valid=0.

Optional Feature:
ICACHE_STATS_EN: when defined, adds outputs stat_hits[31:0] and stat_misses[31:0]. Each counts accepted requests by outcome, saturates at 2^32-1, is cleared by rst, and is unaffected by flush. When undefined, the ports and counters do not exist.

Decomposition:
- Package icache_pkg holds the state enum (IDLE, REFILL_REQ, REFILL_WAIT, RESPOND), localparam-derived widths (OFFSET_W, INDEX_W, TAG_W), and the NOP constant 32'h0000_0013.
- Sub-module icache_line_store holds the data, tag and valid arrays. It provides a 1-read/1-write port, a beat write enable, and a flush-all input.

Test Plan (defaults; index=addr[9:4], tag=addr[31:10]):
- After rst, fetch 0x0 is a miss: mem_req_addr=0x0, then beats 0x00500093, 0x00300113, 0x002081b3, 0x40208233. Response 0x00500093 arrives one cycle after the last beat. Fetch 0x8 then hits with 0x002081b3 the next cycle and no mem_req_valid.
- Conflict: after the line at 0x0 is filled, fetch 0x400 (index 0, tag 1) misses with mem_req_addr=0x400. Refetching 0x0 misses again with mem_req_addr=0x0.
- Hold mem_req_ready=0 for 5 cycles: mem_req_valid=1 and mem_req_addr stay stable, and fetch_req_ready=0 throughout.
- Assert flush during REFILL_WAIT for 0x20: 0x20's word is still returned, and the next fetch of 0x20 misses.
- Assert rst after the 2nd refill beat: the next cycle is IDLE with fetch_rsp_valid=0 and mem_req_valid=0, and late beats are ignored. Fetch 0x0 then misses.
- With ICACHE_STATS_EN: sequence 0x0, 0x4, 0x8, 0x400, 0x0 gives stat_hits=2 and stat_misses=3.
